cmp_search: RTL and testbench



---
 rtl/cmp_search_pkg.sv | 20 ++
 rtl/cmp_search_bounds.sv | 45 ++++
 rtl/cmp_search.sv | 137 +++++++++++++
 tb/tb_cmp_search.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_search_pkg.sv
// Shared types and constants for the cmp_search successive-approximation controller.
// Optional strict flag checking is selected with the CMP_SEARCH_ERRCHK_EN macro.
package cmp_search_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StProbe,
        StDone
    } state_e;

    // Comparator flag vector encodings, ordered {gt, eq, lt}
    localparam logic [2:0] FlagGt = 3'b100;
    localparam logic [2:0] FlagEq = 3'b010;
    localparam logic [2:0] FlagLt = 3'b001;

    function automatic bit width_legal(int unsigned w);
        return (w >= 2) && (w <= 16);
    endfunction

endpackage

// File: rtl/cmp_search_bounds.sv
// Search-window registers for cmp_search: holds lo/hi, produces the midpoint guess
// and flags when the window about to be loaded is empty.
module cmp_search_bounds #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         step_up,
    input  logic         step_dn,
    output logic [W-1:0] mid,
    output logic         exhausted
);

    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W:0]   sum;

    always_comb begin
        // Sum kept at W+1 bits so lo+hi never wraps
        sum  = {1'b0, lo_q} + {1'b0, hi_q};
        mid  = W'(sum >> 1);
        lo_d = lo_q;
        hi_d = hi_q;
        if (init) begin
            lo_d = '0;
            hi_d = '1;
        end else begin
            if (step_up) lo_d = mid + 1'b1;
            if (step_dn) hi_d = mid - 1'b1;
        end
        exhausted = lo_d > hi_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '1;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

endmodule

// File: rtl/cmp_search.sv
// Binary-search initiator toward an external combinational magnitude comparator.
// Define CMP_SEARCH_ERRCHK_EN to require one-hot flags and report violations on err.
module cmp_search
    import cmp_search_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         gt,
    input  logic         eq,
    input  logic         lt,
    output logic [W-1:0] guess,
    output logic         probe,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [W-1:0] result,
    output logic         err
);

    localparam logic [W-1:0] MaxVal = '1;

    if (!width_legal(W)) begin : g_bad_width
        $error("cmp_search: W must be within 2..16");
    end

    state_e       state_q, state_d;
    logic [W-1:0] mid;
    logic [W-1:0] guess_q;
    logic [W-1:0] result_q;
    logic         found_q;
    logic         err_q;
    logic         exhausted;
    logic         in_probe, init;
    logic         take_eq, take_gt, take_lt, bad;
    logic         at_max, at_zero;
    logic         step_up, step_dn;

    always_comb begin
        take_eq = 1'b0;
        take_gt = 1'b0;
        take_lt = 1'b0;
        bad     = 1'b0;
`ifdef CMP_SEARCH_ERRCHK_EN
        case ({gt, eq, lt})
            FlagEq:  take_eq = 1'b1;
            FlagGt:  take_gt = 1'b1;
            FlagLt:  take_lt = 1'b1;
            default: bad     = 1'b1;
        endcase
`else
        // eq wins, then gt; anything else (including no flag) counts as lt
        take_eq = eq;
        take_gt = !eq && gt;
        take_lt = !eq && !gt;
`endif
        in_probe = (state_q == StProbe);
        init     = (state_q == StIdle) && start;
        at_max   = (mid == MaxVal);
        at_zero  = (mid == '0);
        step_up  = in_probe && take_lt && !at_max;
        step_dn  = in_probe && take_gt && !at_zero;
    end

    cmp_search_bounds #(
        .W (W)
    ) u_bounds (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .step_up   (step_up),
        .step_dn   (step_dn),
        .mid       (mid),
        .exhausted (exhausted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StProbe;
            end
            StProbe: begin
                if (take_eq || bad || (take_lt && at_max) || (take_gt && at_zero) || exhausted) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        probe  = in_probe;
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        guess  = in_probe ? mid : guess_q;
        found  = found_q;
        result = result_q;
`ifdef CMP_SEARCH_ERRCHK_EN
        err    = err_q;
`else
        err    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guess_q  <= '0;
            found_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (init) begin
            found_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (in_probe) begin
            guess_q <= mid;
            if (take_eq) begin
                found_q  <= 1'b1;
                result_q <= mid;
            end
            if (bad) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmp_search.sv
// Directed bench for cmp_search (W=4) with a behavioural comparator model.
// Honours CMP_SEARCH_ERRCHK_EN to pick the expected outcome of the illegal-flag case.
module tb_cmp_search;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       gt, eq, lt;
    logic [3:0] guess;
    logic       probe, busy, done, found, err;
    logic [3:0] result;

    int         mode;      // 0: real comparator, 1: always lt, 2: gt+lt together
    logic [3:0] target;
    int         errors = 0;
    int         checks = 0;
    int         exp_q[$];

    always #5 clk = ~clk;

    cmp_search #(
        .W (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .gt     (gt),
        .eq     (eq),
        .lt     (lt),
        .guess  (guess),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .err    (err)
    );

    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        case (mode)
            0: begin
                gt = guess > target;
                eq = guess == target;
                lt = guess < target;
            end
            1: lt = 1'b1;
            default: begin
                gt = 1'b1;
                lt = 1'b1;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one sampled edge; returns at the negedge of the first probe cycle.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Walks the expected guess sequence in exp_q, then the done cycle and the idle cycle.
    task automatic run_checks(input string name, input logic exp_found, input logic [3:0] exp_res,
                              input logic exp_err);
        int last;
        last = exp_q[exp_q.size()-1];
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            check({name, " probe"}, probe, 1);
            check({name, " guess"}, guess, exp_q[i]);
            check({name, " busy"}, busy, 1);
            check({name, " no done"}, done, 0);
        end
        @(negedge clk);
        check({name, " done"}, done, 1);
        check({name, " probe off"}, probe, 0);
        check({name, " found"}, found, exp_found);
        check({name, " result"}, result, exp_res);
        check({name, " err"}, err, exp_err);
        check({name, " guess hold"}, guess, last);
        @(negedge clk);
        check({name, " done pulse"}, done, 0);
        check({name, " idle busy"}, busy, 0);
        check({name, " idle guess"}, guess, last);
        check({name, " held found"}, found, exp_found);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 0;
        target = 4'd0;
        repeat (2) @(negedge clk);
        check("rst guess", guess, 0);
        check("rst probe", probe, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst found", found, 0);
        check("rst result", result, 0);
        check("rst err", err, 0);
        rst_n = 1'b1;

        // Target 11: two probes, done three cycles after start
        target = 4'd11;
        pulse_start();
        exp_q = {7, 11};
        run_checks("t11", 1'b1, 4'd11, 1'b0);

        target = 4'd0;
        pulse_start();
        exp_q = {7, 3, 1, 0};
        run_checks("t0", 1'b1, 4'd0, 1'b0);

        target = 4'd15;
        pulse_start();
        exp_q = {7, 11, 13, 14, 15};
        run_checks("t15", 1'b1, 4'd15, 1'b0);

        // Comparator stuck at lt: search runs off the top of the range
        mode = 1;
        pulse_start();
        exp_q = {7, 11, 13, 14, 15};
        run_checks("all_lt", 1'b0, 4'd0, 1'b0);
        mode = 0;

        // start held high: ignored while busy, relaunches from IDLE
        target = 4'd11;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        check("hold g0", guess, 7);
        @(negedge clk);
        check("hold g1", guess, 11);
        @(negedge clk);
        check("hold done", done, 1);
        @(negedge clk);
        check("hold idle", busy, 0);
        check("hold idle found", found, 1);
        @(negedge clk) start = 1'b0;
        check("hold relaunch probe", probe, 1);
        check("hold relaunch guess", guess, 7);
        @(negedge clk);
        @(negedge clk);
        check("hold relaunch done", done, 1);
        check("hold relaunch result", result, 11);
        @(negedge clk);

        // gt and lt together on the first probe
        mode = 2;
        pulse_start();
        check("gtlt g0", guess, 7);
        @(posedge clk);
        #1 mode = 0;
        target = 4'd3;
`ifdef CMP_SEARCH_ERRCHK_EN
        @(negedge clk);
        check("gtlt done", done, 1);
        check("gtlt err", err, 1);
        check("gtlt found", found, 0);
`else
        @(negedge clk);
        check("gtlt g1", guess, 3);
        check("gtlt probe", probe, 1);
        @(negedge clk);
        check("gtlt done", done, 1);
        check("gtlt found", found, 1);
        check("gtlt result", result, 3);
        check("gtlt err", err, 0);
`endif
        @(negedge clk);

        // Asynchronous reset during the third probe
        target = 4'd15;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("rstmid g2", guess, 13);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid guess", guess, 0);
        check("rstmid probe", probe, 0);
        check("rstmid busy", busy, 0);
        check("rstmid done", done, 0);
        check("rstmid found", found, 0);
        check("rstmid result", result, 0);
        check("rstmid err", err, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid no done", done, 0);
        end
        rst_n = 1'b1;
        target = 4'd11;
        pulse_start();
        exp_q = {7, 11};
        run_checks("after_rst", 1'b1, 4'd11, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
